// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator with a built-in
//               test-pattern source. A board-clock divider produces a pixel
//               tick; on each tick the h/v raster counters advance and every
//               output is re-registered for the new (h_count, v_count) pixel,
//               so all outputs always describe the same pixel.
// Ports       : board_clock  - board clock (single clock domain)
//               reset_n      - asynchronous active-low reset
//               enable       - run when high, freeze everything when low
//               pattern_sel  - test pattern select, latched at frame start
//               hsync/vsync  - sync outputs, active level HS_POL/VS_POL
//               de           - active-video data enable
//               x_val/y_val  - active pixel coordinates (0 when de=0)
//               h_count/v_count         - raw raster counters
//               line_start/frame_start  - one-tick strobes at h=0 / (0,0)
//               red/green/blue          - pattern pixel data
// Macro       : VGA_PATTERN_EN - compiles in the pattern generator; when
//               undefined red/green/blue are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 12,
  parameter int XW       = 10
) (
  input  logic          board_clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x_val,
  output logic [XW-1:0] y_val,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  // Low until the first tick after reset: that tick presents pixel (0,0)
  // without advancing, so the raster starts with de/line/frame strobes set.
  logic          r_started;
  logic          w_tick;
  logic [CW-1:0] w_h_nxt;
  logic [CW-1:0] w_v_nxt;
  logic          w_de_nxt;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_ls_nxt;
  logic          w_fs_nxt;

  assign w_tick = enable && (r_div == C_DIV_LAST);

  // Raster position that the outputs will describe after the coming tick.
  always_comb begin
    w_h_nxt = h_count;
    w_v_nxt = v_count;
    if (r_started) begin
      if (h_count == CW'(H_TOTAL - 1)) begin
        w_h_nxt = '0;
        if (v_count == CW'(V_TOTAL - 1)) begin
          w_v_nxt = '0;
        end else begin
          w_v_nxt = v_count + 1'b1;
        end
      end else begin
        w_h_nxt = h_count + 1'b1;
      end
    end
  end

  // Output decode is done on the next position so the registered outputs
  // line up with the registered counters (zero pixel latency).
  always_comb begin
    w_de_nxt = (w_h_nxt < CW'(H_ACTIVE)) && (w_v_nxt < CW'(V_ACTIVE));
    w_hs_act = (w_h_nxt >= CW'(H_ACTIVE + H_FP)) &&
               (w_h_nxt <  CW'(H_ACTIVE + H_FP + H_SYNC));
    // Vertical sync is a per-line decision, so it only moves at h==0.
    w_vs_act = (w_v_nxt >= CW'(V_ACTIVE + V_FP)) &&
               (w_v_nxt <  CW'(V_ACTIVE + V_FP + V_SYNC));
    w_ls_nxt = (w_h_nxt == '0);
    w_fs_nxt = w_ls_nxt && (w_v_nxt == '0);
  end

  always_ff @(posedge board_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div       <= '0;
      r_started   <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x_val       <= '0;
      y_val       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (enable) begin
        r_div <= (r_div == C_DIV_LAST) ? '0 : r_div + 1'b1;
      end
      if (w_tick) begin
        r_started   <= 1'b1;
        h_count     <= w_h_nxt;
        v_count     <= w_v_nxt;
        hsync       <= w_hs_act ? HS_POL : ~HS_POL;
        vsync       <= w_vs_act ? VS_POL : ~VS_POL;
        de          <= w_de_nxt;
        x_val       <= w_de_nxt ? w_h_nxt[XW-1:0] : '0;
        y_val       <= w_de_nxt ? w_v_nxt[XW-1:0] : '0;
        line_start  <= w_ls_nxt;
        frame_start <= w_fs_nxt;
      end else if (!enable) begin
        // Frozen raster: everything holds, but strobes must not repeat.
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

`ifdef VGA_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [1:0]    r_pat;
  logic [1:0]    w_pat;
  logic [CW-1:0] w_bar;
  logic [2:0]    w_bar_idx;
  logic [23:0]   w_rgb_nxt;
  logic [23:0]   r_rgb;

  always_comb begin
    // The frame_start pixel already uses the newly sampled selection.
    w_pat     = w_fs_nxt ? pattern_sel : r_pat;
    w_bar     = w_h_nxt / CW'(BAR_W);
    w_bar_idx = (w_bar > CW'(7)) ? 3'd7 : w_bar[2:0];
    w_rgb_nxt = '0;
    if (w_de_nxt) begin
      case (w_pat)
        // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
        // R=~idx[1], G=~idx[2], B=~idx[0].
        2'd0: w_rgb_nxt = {{8{~w_bar_idx[1]}}, {8{~w_bar_idx[2]}}, {8{~w_bar_idx[0]}}};
        2'd1: w_rgb_nxt = (w_h_nxt[5] ^ w_v_nxt[5]) ? 24'hFF_FFFF : 24'h00_0000;
        2'd2: w_rgb_nxt = {w_h_nxt[7:0], w_v_nxt[7:0], w_h_nxt[7:0] ^ w_v_nxt[7:0]};
        default: w_rgb_nxt = 24'hFF_FFFF;
      endcase
    end
  end

  always_ff @(posedge board_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pat <= 2'd0;
      r_rgb <= '0;
    end else if (w_tick) begin
      r_rgb <= w_rgb_nxt;
      if (w_fs_nxt) begin
        r_pat <= pattern_sel;
      end
    end
  end

  assign red   = r_rgb[23:16];
  assign green = r_rgb[15:8];
  assign blue  = r_rgb[7:0];
`else
  logic w_unused_pattern_sel;
  assign w_unused_pattern_sel = ^pattern_sel;
  assign red   = '0;
  assign green = '0;
  assign blue  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench for vga_timing_gen. Three instances share the
//               clock and reset: 'a' uses the default 640x480 timing, 'b' a
//               mid-size raster (80x54 total, CLK_DIV=2) used for freeze,
//               pattern and mid-frame reset scenarios, 'c' a tiny raster
//               (8x6 total, CLK_DIV=1, active-high hsync).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en_b = 1'b1;
  logic [1:0] psel = 2'd0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_hs, a_vs, a_de, a_ls, a_fs;
  logic [9:0]  a_x, a_y;
  logic [11:0] a_h, a_v;
  logic [7:0]  a_r, a_g, a_b;
  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0]  b_x, b_y;
  logic [11:0] b_h, b_v;
  logic [7:0]  b_r, b_g, b_b;
  logic        c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0]  c_x, c_y;
  logic [11:0] c_h, c_v;
  logic [7:0]  c_r, c_g, c_b;

  vga_timing_gen u_a (
    .board_clock(clk), .reset_n(reset_n), .enable(1'b1), .pattern_sel(psel),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .x_val(a_x), .y_val(a_y),
    .h_count(a_h), .v_count(a_v), .line_start(a_ls), .frame_start(a_fs),
    .red(a_r), .green(a_g), .blue(a_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2)
  ) u_b (
    .board_clock(clk), .reset_n(reset_n), .enable(en_b), .pattern_sel(psel),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x_val(b_x), .y_val(b_y),
    .h_count(b_h), .v_count(b_v), .line_start(b_ls), .frame_start(b_fs),
    .red(b_r), .green(b_g), .blue(b_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1)
  ) u_c (
    .board_clock(clk), .reset_n(reset_n), .enable(1'b1), .pattern_sel(psel),
    .hsync(c_hs), .vsync(c_vs), .de(c_de), .x_val(c_x), .y_val(c_y),
    .h_count(c_h), .v_count(c_v), .line_start(c_ls), .frame_start(c_fs),
    .red(c_r), .green(c_g), .blue(c_b)
  );

  // Pulse reset and release it on a falling edge.
  task automatic do_reset();
    en_b = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Advance until instance b shows pixel (h,v); an expired budget fails.
  task automatic wait_b(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b_h == h && b_v == v) && n < 20000);
    checks++;
    if (!(b_h == h && b_v == v)) begin
      errors++;
      $display("FAIL wait_b(%0d,%0d) timeout at h=%0d v=%0d", h, v, b_h, b_v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_hs, a_vs, a_de, a_ls, a_fs} !== 5'b11000) begin
      errors++; $display("FAIL reset_ctrl got %b expected 11000", {a_hs, a_vs, a_de, a_ls, a_fs});
    end
    checks++;
    if ({a_h, a_v} !== 24'd0) begin
      errors++; $display("FAIL reset_cnt got h=%0d v=%0d expected 0 0", a_h, a_v);
    end
    checks++;
    if ({a_x, a_y, a_r, a_g, a_b} !== 44'd0) begin
      errors++; $display("FAIL reset_data got x=%0d y=%0d rgb=%h expected 0", a_x, a_y, {a_r, a_g, a_b});
    end
    checks++;
    if ({c_hs, c_vs} !== 2'b01) begin
      errors++; $display("FAIL reset_pol got %b expected 01", {c_hs, c_vs});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_fs, c_ls, c_de, c_x, c_h} !== {3'b111, 10'd0, 12'd0}) begin
      errors++; $display("FAIL first_tick_div1 got fs=%b ls=%b de=%b x=%0d h=%0d expected 1 1 1 0 0",
                         c_fs, c_ls, c_de, c_x, c_h);
    end
    checks++;
    if ({a_de, a_fs} !== 2'b00) begin
      errors++; $display("FAIL pre_tick_div2 got de=%b fs=%b expected 0 0", a_de, a_fs);
    end
    @(negedge clk);
    checks++;
    if ({a_fs, a_ls, a_de, a_x, a_h} !== {3'b111, 10'd0, 12'd0}) begin
      errors++; $display("FAIL first_tick_div2 got fs=%b ls=%b de=%b x=%0d h=%0d expected 1 1 1 0 0",
                         a_fs, a_ls, a_de, a_x, a_h);
    end
    @(negedge clk);
    checks++;
    if (a_fs !== 1'b1) begin
      errors++; $display("FAIL fs_width_hold got %b expected 1", a_fs);
    end
    @(negedge clk);
    checks++;
    if ({a_fs, a_h} !== {1'b0, 12'd1}) begin
      errors++; $display("FAIL fs_width_end got fs=%b h=%0d expected 0 1", a_fs, a_h);
    end
  endtask

  // Tiny raster: pixel i after release is (i%8, (i/8)%6); check all outputs.
  task automatic test_small_raster();
    int h, v;
    logic ed;
    logic [23:0] erg;
    logic [72:0] got, exp;
    psel = 2'd3;
    do_reset();
    for (int i = 0; i < 104; i++) begin
      @(negedge clk);
      h = i % 8;
      v = (i / 8) % 6;
      ed = (h < 4) && (v < 3);
`ifdef VGA_PATTERN_EN
      erg = ed ? 24'hFF_FFFF : 24'h0;
`else
      erg = 24'h0;
`endif
      exp = {12'(h), 12'(v), ed, (h == 0), (h == 0 && v == 0), (h == 5 || h == 6), (v != 4),
             (ed ? 10'(h) : 10'd0), (ed ? 10'(v) : 10'd0), erg};
      got = {c_h, c_v, c_de, c_ls, c_fs, c_hs, c_vs, c_x, c_y, c_r, c_g, c_b};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL small_pixel_%0d got %h expected %h", i, got, exp);
      end
    end
  endtask

  // Default timing, first line: 1600-clock period, hsync low h 656..751.
  task automatic test_line_timing();
    int first_ls, second_ls, hs_low, hs_first, hs_last, de_cnt;
    logic prev_ls;
    first_ls = -1; second_ls = -1; hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
    prev_ls = 1'b0;
    psel = 2'd0;
    do_reset();
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk);
      if (a_ls && !prev_ls) begin
        if (first_ls < 0) first_ls = n;
        else if (second_ls < 0) second_ls = n;
      end
      prev_ls = a_ls;
      if (first_ls >= 0 && second_ls < 0) begin
        if (!a_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(a_h);
          hs_last = int'(a_h);
        end
        if (a_de) de_cnt++;
      end
    end
    checks++;
    if (second_ls - first_ls != 1600) begin
      errors++; $display("FAIL line_period got %0d expected 1600", second_ls - first_ls);
    end
    checks++;
    if (hs_low != 192) begin
      errors++; $display("FAIL hsync_low_clocks got %0d expected 192", hs_low);
    end
    checks++;
    if (hs_first != 656 || hs_last != 751) begin
      errors++; $display("FAIL hsync_range got %0d..%0d expected 656..751", hs_first, hs_last);
    end
    checks++;
    if (de_cnt != 1280) begin
      errors++; $display("FAIL de_clocks got %0d expected 1280", de_cnt);
    end
    checks++;
    if ({a_v, a_vs} !== {12'd1, 1'b1}) begin
      errors++; $display("FAIL line_wrap got v=%0d vs=%b expected 1 1", a_v, a_vs);
    end
  endtask

  task automatic test_freeze();
    int bad;
    psel = 2'd0;
    do_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({b_fs, b_h} !== {1'b1, 12'd0}) begin
      errors++; $display("FAIL freeze_fs_pre got fs=%b h=%0d expected 1 0", b_fs, b_h);
    end
    en_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b_fs, b_ls, b_de, b_h} !== {3'b001, 12'd0}) begin
      errors++; $display("FAIL freeze_strobe got fs=%b ls=%b de=%b h=%0d expected 0 0 1 0",
                         b_fs, b_ls, b_de, b_h);
    end
    en_b = 1'b1;
    wait_b(30, 0);
    en_b = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({b_h, b_v, b_x, b_de, b_ls, b_fs, b_hs} !== {12'd30, 12'd0, 10'd30, 4'b1001}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL freeze_hold got %0d bad clocks expected 0 (h=%0d)", bad, b_h);
    end
    en_b = 1'b1;
    @(negedge clk);
    checks++;
    if (b_h !== 12'd30) begin
      errors++; $display("FAIL resume_div got h=%0d expected 30", b_h);
    end
    @(negedge clk);
    checks++;
    if ({b_h, b_x} !== {12'd31, 10'd31}) begin
      errors++; $display("FAIL resume_step got h=%0d x=%0d expected 31 31", b_h, b_x);
    end
  endtask

  task automatic test_pattern();
`ifdef VGA_PATTERN_EN
    int          bx[9];
    logic [23:0] bc[9];
    bx = '{0, 8, 16, 24, 32, 40, 48, 56, 63};
    bc = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
           24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};
    psel = 2'd0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      wait_b(bx[k], 0);
      checks++;
      if ({b_r, b_g, b_b} !== bc[k]) begin
        errors++; $display("FAIL bar_x%0d got %h expected %h", bx[k], {b_r, b_g, b_b}, bc[k]);
      end
    end
    wait_b(0, 20);
    psel = 2'd1;
    wait_b(32, 30);
    checks++;
    if ({b_r, b_g, b_b} !== 24'hFF00FF) begin
      errors++; $display("FAIL bars_continue got %h expected ff00ff", {b_r, b_g, b_b});
    end
    wait_b(70, 30);
    checks++;
    if ({b_de, b_r, b_g, b_b} !== 25'd0) begin
      errors++; $display("FAIL blank_rgb got de=%b rgb=%h expected 0 000000", b_de, {b_r, b_g, b_b});
    end
    wait_b(0, 0);
    checks++;
    if ({b_fs, b_r, b_g, b_b} !== {1'b1, 24'h000000}) begin
      errors++; $display("FAIL checker_00 got fs=%b rgb=%h expected 1 000000", b_fs, {b_r, b_g, b_b});
    end
    wait_b(32, 0);
    checks++;
    if ({b_r, b_g, b_b} !== 24'hFFFFFF) begin
      errors++; $display("FAIL checker_32_0 got %h expected ffffff", {b_r, b_g, b_b});
    end
    wait_b(0, 32);
    checks++;
    if ({b_r, b_g, b_b} !== 24'hFFFFFF) begin
      errors++; $display("FAIL checker_0_32 got %h expected ffffff", {b_r, b_g, b_b});
    end
    wait_b(32, 32);
    checks++;
    if ({b_r, b_g, b_b} !== 24'h000000) begin
      errors++; $display("FAIL checker_32_32 got %h expected 000000", {b_r, b_g, b_b});
    end
    psel = 2'd2;
    wait_b(5, 3);
    checks++;
    if ({b_r, b_g, b_b} !== 24'h050306) begin
      errors++; $display("FAIL gradient_5_3 got %h expected 050306", {b_r, b_g, b_b});
    end
`else
    psel = 2'd3;
    do_reset();
    wait_b(32, 0);
    checks++;
    if ({b_de, b_r, b_g, b_b} !== {1'b1, 24'h0}) begin
      errors++; $display("FAIL nopat_32_0 got de=%b rgb=%h expected 1 000000", b_de, {b_r, b_g, b_b});
    end
    wait_b(5, 3);
    checks++;
    if ({b_de, b_r, b_g, b_b} !== {1'b1, 24'h0}) begin
      errors++; $display("FAIL nopat_5_3 got de=%b rgb=%h expected 1 000000", b_de, {b_r, b_g, b_b});
    end
`endif
  endtask

  task automatic test_async_reset();
    psel = 2'd0;
    wait_b(40, 20);
    checks++;
    if ({b_de, b_x, b_y} !== {1'b1, 10'd40, 10'd20}) begin
      errors++; $display("FAIL pre_reset got de=%b x=%0d y=%0d expected 1 40 20", b_de, b_x, b_y);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({b_h, b_v, b_hs, b_vs, b_de, b_ls, b_fs, b_x, b_y, b_r, b_g, b_b} !==
        {24'd0, 5'b11000, 20'd0, 24'd0}) begin
      errors++; $display("FAIL async_reset got h=%0d v=%0d hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h expected reset values",
                         b_h, b_v, b_hs, b_vs, b_de, b_x, b_y, {b_r, b_g, b_b});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({b_fs, b_ls, b_de, b_h, b_v} !== {3'b111, 24'd0}) begin
      errors++; $display("FAIL restart got fs=%b ls=%b de=%b h=%0d v=%0d expected 1 1 1 0 0",
                         b_fs, b_ls, b_de, b_h, b_v);
    end
  endtask

  initial begin
    test_reset();
    test_small_raster();
    test_line_timing();
    test_freeze();
    test_pattern();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
